sevenseg_scan_driver: RTL
=========================

// Module: sevenseg_scan_driver
// PURPOSE
//  Time-multiplexes NUM_DIGITS pre-encoded 7-segment patterns onto one shared segment bus.
//  It drives one digit-select line at a time, with a blanking gap between digits to prevent ghosting.
//  It sits directly downstream of the segment7 encoders and drives the io_out segment/digit pads.
//  Double-buffered so that updates never tear a frame.
// PARAMETERS
//  NUM_DIGITS     4     number of digits scanned; >=1
//  PRESCALE       1000  clk cycles per digit slot; >=2
//  BLANK_CYCLES   16    cycles at the start of each slot with all outputs inactive; <PRESCALE
//  SEG_ACTIVE_LOW 0     1: seg_out inverted (lit segment = 0)
//  DIG_ACTIVE_LOW 0     1: dig_out inverted (selected digit = 0)
// PORTS
//  clk         in   1             system clock
//  rstn        in   1             asynchronous active-low reset
//  en          in   1             scan enable
//  load        in   1             1-cycle strobe: capture seg_in
//  seg_in      in   7*NUM_DIGITS  digit i pattern at [7i+6:7i], bit order gfedcba, 1 = lit
//  seg_out     out  7             shared segment lines (polarity per SEG_ACTIVE_LOW)
//  dig_out     out  NUM_DIGITS    one-hot digit select (polarity per DIG_ACTIVE_LOW)
//  frame_done  out  1             1-cycle pulse at each frame wrap
// BEHAVIOUR
//  - State:
//      tick counter 0..PRESCALE-1, digit index idx 0..NUM_DIGITS-1, both $clog2-sized.
//      disp buffer and pending buffer, 7*NUM_DIGITS bits each.
//      pend_v flag; all outputs registered.
//  - Reset (async, rstn=0):
//      tick=0, idx=0, disp=0, pending=0, pend_v=0, frame_done=0.
//      seg_out and dig_out go to their inactive levels immediately, without waiting for clk.
//  - Enabled (en=1), per cycle:
//      tick<PRESCALE-1: tick++.
//      tick==PRESCALE-1: tick=0, idx++, or idx=0 when idx==NUM_DIGITS-1 (frame wrap).
//  - Outputs, 1-cycle latency from (idx,tick):
//      tick<BLANK_CYCLES: all seg/dig inactive.
//      otherwise: dig_out bit idx active, others inactive, and seg_out = disp[idx].
//  - Frame wrap (last tick of digit NUM_DIGITS-1, en=1):
//      If load=1 in that same cycle: disp<=seg_in (bypass).
//      Else if pend_v=1: disp<=pending.
//      pend_v<=0 in both cases.
//      frame_done=1 for exactly the next cycle.
//  - load with en=1, not a wrap cycle: pending<=seg_in, pend_v<=1.
//      Multiple loads before a wrap: the last one wins.
//      disp is unchanged mid-frame.
//  - en=0:
//      tick=0 and idx=0 held.
//      Outputs inactive from the next cycle; frame_done=0.
//      load writes disp directly and clears pend_v.
//  - en rising: the scan starts at idx=0, tick=0, so the first BLANK_CYCLES are blank.
//      A pending update applies only at the first wrap.
//  - en falling mid-slot: the slot is abandoned; no swap, no frame_done.
//  - Exactly one dig_out line is ever active.
//      No segment is lit while tick<BLANK_CYCLES.
// TESTING  (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, polarities 0 unless stated)
//  1 Reset/idle:
//    - rstn=0 -> seg_out=7'h00, dig_out=4'b0000, frame_done=0.
//    - Release with en=0 -> outputs stay 0.
//  2 Scan order:
//    - en=0, then load seg_in={7'h4F,7'h5B,7'h06,7'h3F}, then en=1.
//    - Per slot: 2 cycles blank, then 6 cycles of (dig_out=0001, seg_out=3F), then (0010,06), (0100,5B), (1000,4F).
//    - frame_done pulses once every 32 cycles.
//  3 Tear-free update:
//    - en=1, load all-7'h7F during digit-1 slot -> digits 2 and 3 still show 5B and 4F.
//    - Next frame shows 7F on every digit.
//  4 Simultaneous wrap+load:
//    - load A mid-frame, then load B on the last tick of digit 3.
//    - Next frame shows B; pend_v=0 afterwards, so A is never displayed.
//  5 Enable drop:
//    - en=0 at tick 5 of digit 2 -> next cycle dig_out=0, seg_out=0, no frame_done.
//    - en=1 -> restarts at digit 0 with 2 blank cycles.
//  6 Async reset + polarity:
//    - SEG_ACTIVE_LOW=DIG_ACTIVE_LOW=1; rstn low mid-slot, between clk edges.
//    - Same instant -> seg_out=7'h7F, dig_out=4'b1111.
//    - After restart, a lit digit 06 shows seg_out=7'h79, dig_out=4'b1110.

Source files
------------

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver
//   Time-multiplexes NUM_DIGITS pre-encoded 7-segment patterns onto one shared
//   segment bus. One digit-select line is active at a time. Every digit slot
//   opens with a blanking gap so the previous digit's pattern never ghosts
//   onto the next one. Display data is double-buffered, so a frame is never torn.
//
// Ports
//   clk         system clock
//   rstn        asynchronous active-low reset
//   en          scan enable
//   load        1-cycle strobe: capture seg_in
//   seg_in      digit i pattern at [7i+6:7i], bit order gfedcba, 1 = lit
//   seg_out     shared segment lines (inverted when SEG_ACTIVE_LOW=1)
//   dig_out     one-hot digit select (inverted when DIG_ACTIVE_LOW=1)
//   frame_done  1-cycle pulse after each frame wrap
module sevenseg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE       = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      en,
    input  logic                      load,
    input  logic [7*NUM_DIGITS-1:0]   seg_in,
    output logic [6:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     dig_out,
    output logic                      frame_done
);

    localparam int TICK_W = $clog2(PRESCALE);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PRESCALE - 1);
    localparam logic [TICK_W-1:0] BLANK_T   = TICK_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // Inactive levels. XOR-ing an active-high value with these applies the
    // pad polarity, since all-ones inverts and all-zeros passes through.
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF =
        (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [TICK_W-1:0]       tick_reg,   tick_next;
    logic [IDX_W-1:0]        idx_reg,    idx_next;
    logic [7*NUM_DIGITS-1:0] disp_reg,   disp_next;
    logic [7*NUM_DIGITS-1:0] pend_reg,   pend_next;
    logic                    pend_v_reg, pend_v_next;
    logic [6:0]              seg_reg,    seg_next;
    logic [NUM_DIGITS-1:0]   dig_reg,    dig_next;
    logic                    fd_reg,     fd_next;

    logic [6:0]            digit_pat [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dig_sel;
    logic                  wrap;

    // Split the display buffer into per-digit patterns and build the
    // active-high one-hot select for the current index.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_pat[gi] = disp_reg[7*gi +: 7];
            assign dig_sel[gi]   = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign wrap = en && (tick_reg == TICK_LAST) && (idx_reg == IDX_LAST);

    always_comb begin
        tick_next   = tick_reg;
        idx_next    = idx_reg;
        disp_next   = disp_reg;
        pend_next   = pend_reg;
        pend_v_next = pend_v_reg;
        seg_next    = SEG_OFF;
        dig_next    = DIG_OFF;
        fd_next     = wrap;

        // Scan position: held at the frame start while disabled.
        if (!en) begin
            tick_next = '0;
            idx_next  = '0;
        end else if (tick_reg == TICK_LAST) begin
            tick_next = '0;
            idx_next  = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
        end else begin
            tick_next = tick_reg + TICK_W'(1);
        end

        // Buffer management. While disabled nothing is shown, so a load can
        // go straight to the display. While scanning, updates are parked in
        // the pending buffer and only swapped in at the frame wrap. A load
        // coinciding with the wrap bypasses the pending buffer entirely.
        if (!en) begin
            if (load) begin
                disp_next   = seg_in;
                pend_v_next = 1'b0;
            end
        end else if (wrap) begin
            if (load) begin
                disp_next = seg_in;
            end else if (pend_v_reg) begin
                disp_next = pend_reg;
            end
            pend_v_next = 1'b0;
        end else if (load) begin
            pend_next   = seg_in;
            pend_v_next = 1'b1;
        end

        // Outputs follow the current (idx, tick) one cycle later.
        if (en && (tick_reg >= BLANK_T)) begin
            seg_next = digit_pat[idx_reg] ^ SEG_OFF;
            dig_next = dig_sel ^ DIG_OFF;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick_reg   <= '0;
            idx_reg    <= '0;
            disp_reg   <= '0;
            pend_reg   <= '0;
            pend_v_reg <= 1'b0;
            seg_reg    <= SEG_OFF;
            dig_reg    <= DIG_OFF;
            fd_reg     <= 1'b0;
        end else begin
            tick_reg   <= tick_next;
            idx_reg    <= idx_next;
            disp_reg   <= disp_next;
            pend_reg   <= pend_next;
            pend_v_reg <= pend_v_next;
            seg_reg    <= seg_next;
            dig_reg    <= dig_next;
            fd_reg     <= fd_next;
        end
    end

    assign seg_out    = seg_reg;
    assign dig_out    = dig_reg;
    assign frame_done = fd_reg;

endmodule
